sort_seq_ctrl: RTL and testbench

SORT_SEQ_CTRL -- requirements
Module: sort_seq_ctrl

---
 rtl/sort_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_sort_seq_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_seq_ctrl.sv
// sort_seq_ctrl: loads up to DEPTH unsigned values, bubble-sorts them in place
// with one compare-swap per cycle, then streams them out with a valid/ready
// handshake.
// Optional feature macro: SORT_DESC_EN adds a 'desc' input. It is sampled on
// the accepted start and selects descending order for that sort.
module sort_seq_ctrl #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
`ifdef SORT_DESC_EN
   input  logic                       desc,
`endif
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       in_ready,
   input  logic                       start,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_last,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       busy,
   output logic                       done
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(DEPTH);

   typedef enum logic [1:0] {LOAD, SORT, DRAIN} stateT;

   stateT             stateQ, stateD;
   logic [CW-1:0]     countQ, countD;
   logic [IW-1:0]     rdQ, rdD;
   logic [IW-1:0]     jQ, jD;
   logic              swapFlagQ, swapFlagD;
   logic              doneQ, doneD;
   logic [DATA_W-1:0] bufQ [DEPTH];

   logic              loadWe;
   logic              swapWe;
   logic              needSwap;
   logic              lastCompare;
   logic              lastOut;
   logic              descMode;
   logic [DATA_W-1:0] elemA;
   logic [DATA_W-1:0] elemB;

`ifdef SORT_DESC_EN
   logic              descQ, descD;
   assign descMode = descQ;
`else
   assign descMode = 1'b0;
`endif

   // The pair under comparison and whether it is out of order for the chosen direction
   assign elemA       = bufQ[jQ];
   assign elemB       = bufQ[jQ + IW'(1)];
   assign needSwap    = descMode ? (elemA < elemB) : (elemA > elemB);
   assign lastCompare = (CW'(jQ) == (countQ - CW'(2)));
   assign lastOut     = (CW'(rdQ) == (countQ - CW'(1)));

   // Next-state logic: loading, the compare-swap walk, and draining
   always_comb begin
      stateD    = stateQ;
      countD    = countQ;
      rdD       = rdQ;
      jD        = jQ;
      swapFlagD = swapFlagQ;
      doneD     = 1'b0;
      loadWe    = 1'b0;
      swapWe    = 1'b0;
`ifdef SORT_DESC_EN
      descD     = descQ;
`endif
      case (stateQ)
         LOAD: begin
            loadWe = in_valid && (countQ < CW'(DEPTH));
            if (loadWe) begin
               countD = countQ + CW'(1);
            end
            // countD already includes an element written in this same cycle
            if (start && (countD != '0)) begin
               stateD    = SORT;
               jD        = '0;
               swapFlagD = 1'b0;
`ifdef SORT_DESC_EN
               descD     = desc;
`endif
            end
         end
         SORT: begin
            if (countQ == CW'(1)) begin
               stateD = DRAIN;
               rdD    = '0;
            end else begin
               swapWe = needSwap;
               if (lastCompare) begin
                  jD        = '0;
                  swapFlagD = 1'b0;
                  if (!(swapFlagQ || needSwap)) begin
                     stateD = DRAIN;
                     rdD    = '0;
                  end
               end else begin
                  jD        = jQ + IW'(1);
                  swapFlagD = swapFlagQ || needSwap;
               end
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (lastOut) begin
                  doneD  = 1'b1;
                  countD = '0;
                  rdD    = '0;
                  stateD = LOAD;
               end else begin
                  rdD = rdQ + IW'(1);
               end
            end
         end
         default: begin
            stateD = LOAD;
         end
      endcase
   end

   // Control registers, cleared asynchronously so a reset abandons any sort or drain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ    <= LOAD;
         countQ    <= '0;
         rdQ       <= '0;
         jQ        <= '0;
         swapFlagQ <= 1'b0;
         doneQ     <= 1'b0;
`ifdef SORT_DESC_EN
         descQ     <= 1'b0;
`endif
      end else begin
         stateQ    <= stateD;
         countQ    <= countD;
         rdQ       <= rdD;
         jQ        <= jD;
         swapFlagQ <= swapFlagD;
         doneQ     <= doneD;
`ifdef SORT_DESC_EN
         descQ     <= descD;
`endif
      end
   end

   // Element storage has no reset; only the first count entries are ever meaningful
   always_ff @(posedge clk) begin
      if (loadWe) begin
         bufQ[countQ[IW-1:0]] <= in_data;
      end else if (swapWe) begin
         bufQ[jQ]           <= elemB;
         bufQ[jQ + IW'(1)]  <= elemA;
      end
   end

   // Outputs are decoded from the current state so they are correct straight out of reset
   always_comb begin
      in_ready  = (stateQ == LOAD) && (countQ < CW'(DEPTH));
      out_valid = (stateQ == DRAIN);
      out_data  = (stateQ == DRAIN) ? bufQ[rdQ] : '0;
      out_last  = (stateQ == DRAIN) && lastOut;
      busy      = (stateQ == SORT) || (stateQ == DRAIN);
      done      = doneQ;
      count     = countQ;
   end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Testbench for sort_seq_ctrl: a queue-based model predicts every output each
// cycle, and directed tests pin the model with hand-computed sequences.
module tb_sort_seq_ctrl;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int CW     = $clog2(DEPTH+1);

   typedef int intQ[$];
   typedef enum int {M_LOAD, M_SORT, M_DRAIN} mPhaseT;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic              in_valid  = 1'b0;
   logic [DATA_W-1:0] in_data   = '0;
   logic              start     = 1'b0;
   logic              out_ready = 1'b1;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic [CW-1:0]     count;
   logic              busy;
   logic              done;
`ifdef SORT_DESC_EN
   logic              desc      = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   // Model state
   mPhaseT mPhase    = M_LOAD;
   intQ    mLoaded;
   intQ    mSorted;
   int     mSortLeft = 0;
   int     mRd       = 0;
   bit     mDone     = 1'b0;
   bit     mDesc     = 1'b0;

   // Observation state
   intQ    gotQ;
   int     lastIdx        = -1;
   int     doneCount      = 0;
   int     sortCycleCount = 0;
   bit     stalledPrev    = 1'b0;
   int     prevData       = 0;

   sort_seq_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef SORT_DESC_EN
      .desc      (desc),
`endif
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .start     (start),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .count     (count),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic bit outOfOrder(input int a, input int b, input bit dsc);
      return dsc ? (a < b) : (a > b);
   endfunction

   // Expected output order, built by repeated selection of the min (or max)
   function automatic intQ sortedCopy(input intQ src, input bit dsc);
      intQ rest;
      intQ res;
      rest = src;
      while (rest.size() > 0) begin
         int best = 0;
         for (int k = 1; k < rest.size(); k++) begin
            if (dsc ? (rest[k] > rest[best]) : (rest[k] < rest[best])) best = k;
         end
         res.push_back(rest[best]);
         rest.delete(best);
      end
      return res;
   endfunction

   // Cycles spent sorting: full passes of N-1 compares until a pass makes no swap
   function automatic int sortCycles(input intQ src, input bit dsc);
      intQ a;
      int  passes = 0;
      bit  sw;
      a = src;
      if (a.size() == 1) return 1;
      do begin
         sw = 1'b0;
         for (int j = 0; j < a.size() - 1; j++) begin
            if (outOfOrder(a[j], a[j+1], dsc)) begin
               int t = a[j];
               a[j]   = a[j+1];
               a[j+1] = t;
               sw     = 1'b1;
            end
         end
         passes++;
      end while (sw);
      return passes * (a.size() - 1);
   endfunction

   // Behavioural model: advances on the same edges the design does
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mPhase    = M_LOAD;
         mLoaded.delete();
         mSorted.delete();
         mSortLeft = 0;
         mRd       = 0;
         mDone     = 1'b0;
      end else begin
         mDone = 1'b0;
         case (mPhase)
            M_LOAD: begin
               if (in_valid && mLoaded.size() < DEPTH) mLoaded.push_back(int'(in_data));
               if (start && mLoaded.size() > 0) begin
`ifdef SORT_DESC_EN
                  mDesc = desc;
`else
                  mDesc = 1'b0;
`endif
                  mSortLeft = sortCycles(mLoaded, mDesc);
                  mSorted   = sortedCopy(mLoaded, mDesc);
                  mPhase    = M_SORT;
               end
            end
            M_SORT: begin
               mSortLeft--;
               if (mSortLeft == 0) begin
                  mPhase = M_DRAIN;
                  mRd    = 0;
               end
            end
            default: begin
               if (out_ready) begin
                  if (mRd == mLoaded.size() - 1) begin
                     mDone  = 1'b1;
                     mLoaded.delete();
                     mPhase = M_LOAD;
                  end else begin
                     mRd++;
                  end
               end
            end
         endcase
      end
   end

   // Compare process: checks every output against the model on each falling edge
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("in_ready", int'(in_ready), int'(mPhase == M_LOAD && mLoaded.size() < DEPTH));
         checkOutput("count", int'(count), mLoaded.size());
         checkOutput("busy", int'(busy), int'(mPhase != M_LOAD));
         checkOutput("out_valid", int'(out_valid), int'(mPhase == M_DRAIN));
         checkOutput("done", int'(done), int'(mDone));
         if (mPhase == M_DRAIN) begin
            checkOutput("out_data", int'(out_data), mSorted[mRd]);
            checkOutput("out_last", int'(out_last), int'(mRd == mLoaded.size() - 1));
         end
         if (stalledPrev && out_valid) checkOutput("stallHold", int'(out_data), prevData);
         stalledPrev = out_valid && !out_ready;
         prevData    = int'(out_data);
         if (busy && !out_valid) sortCycleCount++;
         if (done) doneCount++;
         if (out_valid && out_ready) begin
            gotQ.push_back(int'(out_data));
            if (out_last) lastIdx = gotQ.size() - 1;
         end
      end else begin
         stalledPrev = 1'b0;
      end
   end

   // One cycle of input drive, applied just after the rising edge
   task automatic applyStimulus(input logic v, input int d, input logic s, input logic r);
      @(posedge clk);
      #2;
      in_valid  = v;
      in_data   = DATA_W'(d);
      start     = s;
      out_ready = r;
   endtask

   task automatic loadList(input intQ vals, input bit startOnLast);
      foreach (vals[i]) applyStimulus(1'b1, vals[i], startOnLast && (i == vals.size() - 1), 1'b1);
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
   endtask

   task automatic startSort();
      applyStimulus(1'b0, 0, 1'b1, 1'b1);
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
   endtask

   task automatic drainToDone(input bit randomReady, input string tag);
      int d0 = doneCount;
      int n  = 0;
      while (doneCount == d0 && n < 800) begin
         applyStimulus(1'b0, 0, 1'b0, randomReady ? 1'($urandom_range(0, 1)) : 1'b1);
         n++;
      end
      repeat (2) applyStimulus(1'b0, 0, 1'b0, 1'b1);
      checkOutput({tag, "_donePulses"}, doneCount - d0, 1);
   endtask

   task automatic checkList(input string tag, input intQ exp);
      checkOutput({tag, "_len"}, gotQ.size(), exp.size());
      for (int i = 0; i < exp.size() && i < gotQ.size(); i++) begin
         checkOutput($sformatf("%s_elem%0d", tag, i), gotQ[i], exp[i]);
      end
   endtask

   initial begin
      intQ v;
      intQ e;
      int  d0;

      // Reset values
      #12;
      checkOutput("rst_in_ready", int'(in_ready), 1);
      checkOutput("rst_count", int'(count), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_out_last", int'(out_last), 0);
      checkOutput("rst_out_data", int'(out_data), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Ten values, full-speed drain
      gotQ.delete();
      lastIdx = -1;
      v = '{4, 80, 13, 27, 35, 67, 31, 43, 67, 42};
      loadList(v, 1'b0);
      startSort();
      drainToDone(1'b0, "t38");
      e = '{4, 13, 27, 31, 35, 42, 43, 67, 67, 80};
      checkList("t38", e);
      checkOutput("t38_lastIdx", lastIdx, 9);
      checkOutput("t38_countAfter", int'(count), 0);

      // Append after earlier loads, start in the same cycle as the last load, random stalls
      gotQ.delete();
      v = '{50, 3, 99, 20, 61, 8, 77, 45, 12, 90};
      loadList(v, 1'b0);
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
      v = '{72, 75, 84, 36, 14};
      loadList(v, 1'b1);
      drainToDone(1'b1, "t39");
      e = '{3, 8, 12, 14, 20, 36, 45, 50, 61, 72, 75, 77, 84, 90, 99};
      checkList("t39", e);

      // Full buffer ignores further data
      gotQ.delete();
      v.delete();
      for (int i = 0; i < DEPTH; i++) v.push_back((i * 37) % 97);
      loadList(v, 1'b0);
      repeat (3) applyStimulus(1'b1, 99, 1'b0, 1'b1);
      checkOutput("t40_countFull", int'(count), 16);
      checkOutput("t40_inReadyFull", int'(in_ready), 0);
      applyStimulus(1'b1, 99, 1'b1, 1'b1);
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
      drainToDone(1'b0, "t40");
      checkOutput("t40_len", gotQ.size(), 16);
      begin
         int hits = 0;
         foreach (gotQ[i]) if (gotQ[i] == 99) hits++;
         checkOutput("t40_no99", hits, 0);
      end

      // Already sorted set: exactly N-1 sort cycles
      gotQ.delete();
      v = '{1, 2, 3, 4};
      loadList(v, 1'b0);
      sortCycleCount = 0;
      startSort();
      drainToDone(1'b0, "t41a");
      checkOutput("t41_sortCycles", sortCycleCount, 3);
      e = '{1, 2, 3, 4};
      checkList("t41a", e);

      // Single element
      gotQ.delete();
      lastIdx = -1;
      v = '{7};
      loadList(v, 1'b0);
      sortCycleCount = 0;
      startSort();
      drainToDone(1'b0, "t41b");
      e = '{7};
      checkList("t41b", e);
      checkOutput("t41b_lastIdx", lastIdx, 0);
      checkOutput("t41b_sortCycles", sortCycleCount, 1);

      // Start with nothing loaded is ignored
      startSort();
      checkOutput("emptyStart_busy", int'(busy), 0);

      // Reset in the middle of a sort
      v = '{9, 8, 7, 6};
      loadList(v, 1'b0);
      startSort();
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
      d0 = doneCount;
      rst_n = 1'b0;
      #1;
      checkOutput("midRst_count", int'(count), 0);
      checkOutput("midRst_busy", int'(busy), 0);
      checkOutput("midRst_in_ready", int'(in_ready), 1);
      checkOutput("midRst_out_valid", int'(out_valid), 0);
      checkOutput("midRst_out_data", int'(out_data), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (30) applyStimulus(1'b0, 0, 1'b0, 1'b1);
      checkOutput("midRst_noDone", doneCount - d0, 0);

`ifdef SORT_DESC_EN
      // Descending order selected at start
      gotQ.delete();
      v = '{5, 9, 1};
      loadList(v, 1'b0);
      desc = 1'b1;
      startSort();
      desc = 1'b0;
      drainToDone(1'b0, "t43desc");
      e = '{9, 5, 1};
      checkList("t43desc", e);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
